neopixel_receiver: RTL

- One-wire WS2812-style decoder; the receive-side counterpart of the neopixel transmitter.
- Samples a single data line and measures high/low pulse widths against the system clock. Decodes bits into 24-bit pixel words and detects the latch (reset) gap that ends a frame.
- Exposes received pixels and status through an Avalon-MM slave.
- Used for loopback test of the LED chain and for receiving colour data from an upstream controller.

---
 rtl/neopixel_pkg.sv | 22 ++
 rtl/neopixel_receiver_pulse_timer.sv | 33 +++
 rtl/neopixel_receiver.sv | 139 +++++++++++++
 3 files changed

// File: rtl/neopixel_pkg.sv
// neopixel_pkg: timing helpers, status bit indices and receiver state encoding shared by the neopixel blocks
package neopixel_pkg;
  localparam int DEFAULT_CLOCK_SPEED_HZ = 50_000_000;
  localparam int DEFAULT_NUMBER_OF_NEOPIXEL = 35;
  localparam int ST_FRAME_VALID = 0;
  localparam int ST_OVERFLOW = 1;
  localparam int ST_PULSE_ERROR = 2;
  localparam int ST_PARTIAL = 3;
  typedef enum logic [1:0] {ARM, IDLE, HIGH, LOW} rx_state_e;
  function automatic int t_min_high(int hz);
    return hz / 10_000_000;
  endfunction
  function automatic int t_bit_thresh(int hz);
    return hz / 2_222_222;
  endfunction
  function automatic int t_max_high(int hz);
    return hz / 666_666;
  endfunction
  function automatic int t_latch(int hz);
    return hz / 20_000;
  endfunction
endpackage

// File: rtl/neopixel_receiver_pulse_timer.sv
// neopixel_pulse_timer: synchronizes the one-wire line, flags its edges and measures the current level's length
module neopixel_pulse_timer (
  input  logic        clock,
  input  logic        reset,
  input  logic        one_wire,
  output logic        line,
  output logic        rise,
  output logic        fall,
  output logic [15:0] width
);
  logic meta_q, sync_q, prev_q;
  logic [15:0] width_q, width_d;
  // restarts at 1 so the value seen on an edge is the full length of the level just ended
  always_comb begin
    rise = sync_q & ~prev_q;
    fall = ~sync_q & prev_q;
    width_d = (rise | fall) ? 16'd1 : (&width_q ? width_q : width_q + 16'd1);
  end
  always_ff @(posedge clock or negedge reset)
    if (!reset) begin
      meta_q <= 1'b0;
      sync_q <= 1'b0;
      prev_q <= 1'b0;
      width_q <= '0;
    end else begin
      meta_q <= one_wire;
      sync_q <= meta_q;
      prev_q <= sync_q;
      width_q <= width_d;
    end
  assign line = sync_q;
  assign width = width_q;
endmodule

// File: rtl/neopixel_receiver.sv
// neopixel_receiver: decodes WS2812 one-wire frames into pixel words readable over Avalon-MM
module neopixel_receiver
  import neopixel_pkg::*;
#(
  parameter int CLOCK_SPEED_HZ = DEFAULT_CLOCK_SPEED_HZ,
  parameter int NUMBER_OF_NEOPIXEL = DEFAULT_NUMBER_OF_NEOPIXEL
) (
  input  logic        clock,
  input  logic        reset,
  input  logic [7:0]  address,
  input  logic        write,
  input  logic [31:0] writedata,
  input  logic        read,
  output logic [31:0] readdata,
  output logic        waitrequest,
  input  logic        one_wire,
  output logic        frame_done
);
  localparam logic [15:0] T_MIN = 16'(t_min_high(CLOCK_SPEED_HZ));
  localparam logic [15:0] T_BIT = 16'(t_bit_thresh(CLOCK_SPEED_HZ));
  localparam logic [15:0] T_MAX = 16'(t_max_high(CLOCK_SPEED_HZ));
  localparam logic [15:0] T_LAT = 16'(t_latch(CLOCK_SPEED_HZ));
  localparam logic [31:0] MAX_BITS = 32'(24 * NUMBER_OF_NEOPIXEL);
  localparam logic [7:0] NP8 = 8'(NUMBER_OF_NEOPIXEL);
  localparam int AW = $clog2(NUMBER_OF_NEOPIXEL);
  localparam int PW = $clog2(NUMBER_OF_NEOPIXEL + 1);
  rx_state_e state_q, state_d;
  logic [31:0] bit_ctr_q, bit_ctr_d, frame_count_q, frame_count_d;
  logic [4:0] bit_pos_q, bit_pos_d;
  logic [PW-1:0] pix_q, pix_d;
  logic [23:0] shift_q, shift_d;
  logic [23:0] pixel_q [NUMBER_OF_NEOPIXEL];
  logic [23:0] pixel_d [NUMBER_OF_NEOPIXEL];
  logic [15:0] pixels_last_q, pixels_last_d;
  logic frame_valid_q, frame_valid_d, overflow_q, overflow_d;
  logic pulse_error_q, pulse_error_d, partial_q, partial_d;
  logic frame_done_q, frame_done_d;
  logic line, rise, fall;
  logic [15:0] width;
  logic [31:0] status;
  logic [AW-1:0] rd_idx;
  logic unused_bus;
  neopixel_pulse_timer u_timer (
    .clock(clock), .reset(reset), .one_wire(one_wire),
    .line(line), .rise(rise), .fall(fall), .width(width)
  );
  always_comb begin
    state_d = state_q;
    bit_ctr_d = bit_ctr_q;
    frame_count_d = frame_count_q;
    bit_pos_d = bit_pos_q;
    pix_d = pix_q;
    shift_d = shift_q;
    pixel_d = pixel_q;
    pixels_last_d = pixels_last_q;
    frame_done_d = 1'b0;
    {frame_valid_d, overflow_d, pulse_error_d, partial_d} = {frame_valid_q, overflow_q, pulse_error_q, partial_q};
    // the clear is applied first so any flag set in the same cycle wins
    if (write && address == 8'd0)
      {frame_valid_d, overflow_d, pulse_error_d, partial_d} = '0;
    case (state_q)
      ARM: if (!line && width >= T_LAT) state_d = IDLE;
      IDLE: if (rise) state_d = HIGH;
      HIGH:
        if (width >= T_MAX) begin
          state_d = ARM;
          pulse_error_d = 1'b1;
          bit_ctr_d = '0;
          bit_pos_d = '0;
          pix_d = '0;
        end else if (fall) begin
          state_d = LOW;
          if (width >= T_MIN && bit_ctr_q >= MAX_BITS)
            overflow_d = 1'b1;
          else if (width >= T_MIN) begin
            shift_d[bit_pos_q] = width >= T_BIT;
            bit_ctr_d = bit_ctr_q + 32'd1;
            bit_pos_d = (bit_pos_q == 5'd23) ? 5'd0 : bit_pos_q + 5'd1;
            pix_d = (bit_pos_q == 5'd23) ? pix_q + PW'(1) : pix_q;
            if (bit_pos_q == 5'd23) pixel_d[AW'(pix_q)] = shift_d;
          end
        end
      LOW:
        if (rise)
          state_d = HIGH;
        else if (width >= T_LAT) begin
          state_d = IDLE;
          if (bit_ctr_q != 32'd0) begin
            frame_valid_d = 1'b1;
            partial_d = bit_pos_q != 5'd0;
            pixels_last_d = 16'(pix_q);
            frame_count_d = frame_count_q + 32'd1;
            bit_ctr_d = '0;
            bit_pos_d = '0;
            pix_d = '0;
            frame_done_d = 1'b1;
          end
        end
    endcase
  end
  always_ff @(posedge clock or negedge reset)
    if (!reset) begin
      state_q <= ARM;
      bit_ctr_q <= '0;
      frame_count_q <= '0;
      bit_pos_q <= '0;
      pix_q <= '0;
      shift_q <= '0;
      pixel_q <= '{default: '0};
      pixels_last_q <= '0;
      {frame_valid_q, overflow_q, pulse_error_q, partial_q} <= '0;
      frame_done_q <= 1'b0;
    end else begin
      state_q <= state_d;
      bit_ctr_q <= bit_ctr_d;
      frame_count_q <= frame_count_d;
      bit_pos_q <= bit_pos_d;
      pix_q <= pix_d;
      shift_q <= shift_d;
      pixel_q <= pixel_d;
      pixels_last_q <= pixels_last_d;
      {frame_valid_q, overflow_q, pulse_error_q, partial_q} <= {frame_valid_d, overflow_d, pulse_error_d, partial_d};
      frame_done_q <= frame_done_d;
    end
  always_comb begin
    status = {pixels_last_q, 16'h0000};
    status[ST_FRAME_VALID] = frame_valid_q;
    status[ST_OVERFLOW] = overflow_q;
    status[ST_PULSE_ERROR] = pulse_error_q;
    status[ST_PARTIAL] = partial_q;
  end
  assign rd_idx = AW'(address - 8'd1);
  assign readdata = (address == 8'd0) ? status :
                    (address <= NP8) ? {8'h00, pixel_q[rd_idx]} :
                    (address == NP8 + 8'd1) ? frame_count_q : 32'hDEAD_BEEF;
  assign waitrequest = 1'b0;
  assign frame_done = frame_done_q;
  assign unused_bus = ^{read, writedata};
endmodule
